// File: rtl/cm_sketch_row_counter.sv
// One count-min sketch row: saturating read-modify-write counters behind a
// 3-stage pipeline, plus the row's zeroing sweep after reset and on request.
module cm_sketch_row_counter #(
    parameter int W         = 4096,
    parameter int HASH_SIZE = $clog2(W),
    parameter int CNT_SIZE  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [HASH_SIZE-1:0] in_hash,
    input  logic                 in_inc,
    input  logic                 clear_req,
    output logic                 clear_busy,
    output logic                 out_valid,
    output logic [CNT_SIZE-1:0]  out_count,
    output logic                 out_sat,
    output logic                 drop
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [HASH_SIZE-1:0] LAST_ADDR = HASH_SIZE'(W - 1);
    localparam logic [CNT_SIZE-1:0]  CNT_MAX   = '1;

    state_t               state_reg, state_next;
    logic [HASH_SIZE-1:0] sweep_addr_reg, sweep_addr_next;
    logic                 sweep_we;

    logic                 accept;

    logic                 s1_valid_reg;
    logic                 s1_inc_reg;
    logic [HASH_SIZE-1:0] s1_hash_reg;

    logic                 fwd_valid_reg;
    logic [HASH_SIZE-1:0] fwd_hash_reg;
    logic [CNT_SIZE-1:0]  fwd_data_reg;

    logic [CNT_SIZE-1:0]  mem [W];
    logic [CNT_SIZE-1:0]  rd_data_reg;
    logic [CNT_SIZE-1:0]  old_value;
    logic [CNT_SIZE-1:0]  new_value;

    logic                 ram_we;
    logic [HASH_SIZE-1:0] ram_addr;
    logic [CNT_SIZE-1:0]  ram_wdata;

    logic                 out_valid_reg;
    logic [CNT_SIZE-1:0]  out_count_reg;
    logic                 out_sat_reg;
    logic                 drop_reg;

    assign accept = in_valid && (state_reg == ST_IDLE) && !clear_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_CLEAR;
            sweep_addr_reg <= '0;
        end else begin
            state_reg      <= state_next;
            sweep_addr_reg <= sweep_addr_next;
        end
    end

    // The input arriving with clear_req is always dropped, so S1 is empty
    // during DRAIN and the first zero write can share that cycle.
    always_comb begin
        state_next      = state_reg;
        sweep_addr_next = sweep_addr_reg;
        sweep_we        = 1'b0;
        case (state_reg)
            ST_CLEAR: begin
                sweep_we        = 1'b1;
                sweep_addr_next = sweep_addr_reg + HASH_SIZE'(1);
                if (sweep_addr_reg == LAST_ADDR) begin
                    state_next      = ST_IDLE;
                    sweep_addr_next = '0;
                end
            end
            ST_IDLE: begin
                if (clear_req) begin
                    state_next      = ST_DRAIN;
                    sweep_addr_next = '0;
                end
            end
            ST_DRAIN: begin
                sweep_we        = 1'b1;
                sweep_addr_next = sweep_addr_reg + HASH_SIZE'(1);
                state_next      = ST_CLEAR;
            end
            default: begin
                state_next      = ST_CLEAR;
                sweep_addr_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s1_inc_reg    <= 1'b0;
            s1_hash_reg   <= '0;
            fwd_valid_reg <= 1'b0;
            fwd_hash_reg  <= '0;
            fwd_data_reg  <= '0;
        end else begin
            s1_valid_reg  <= accept;
            s1_inc_reg    <= in_inc;
            s1_hash_reg   <= in_hash;
            fwd_valid_reg <= s1_valid_reg && s1_inc_reg;
            fwd_hash_reg  <= s1_hash_reg;
            fwd_data_reg  <= new_value;
        end
    end

    // RAM returns pre-write data, so the op just written is forwarded instead.
    assign old_value = (fwd_valid_reg && (fwd_hash_reg == s1_hash_reg)) ? fwd_data_reg : rd_data_reg;

    always_comb begin
        new_value = old_value;
        if (s1_inc_reg && (old_value != CNT_MAX)) begin
            new_value = old_value + CNT_SIZE'(1);
        end
    end

    assign ram_we    = sweep_we || (s1_valid_reg && s1_inc_reg);
    assign ram_addr  = sweep_we ? sweep_addr_reg : s1_hash_reg;
    assign ram_wdata = sweep_we ? '0 : new_value;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        rd_data_reg <= mem[in_hash];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_count_reg <= '0;
            out_sat_reg   <= 1'b0;
            drop_reg      <= 1'b0;
        end else begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_count_reg <= new_value;
                out_sat_reg   <= (new_value == CNT_MAX);
            end
            drop_reg <= in_valid && !accept;
        end
    end

    assign clear_busy = (state_reg != ST_IDLE);
    assign out_valid  = out_valid_reg;
    assign out_count  = out_count_reg;
    assign out_sat    = out_sat_reg;
    assign drop       = drop_reg;

endmodule

// File: tb/tb_cm_sketch_row_counter.sv
// Directed bench for one sketch row: stimulus pushes expected results into a
// queue, a negedge monitor pops and compares each out_valid pulse.
module tb_cm_sketch_row_counter;

    localparam int W  = 16;
    localparam int HS = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [HS-1:0] in_hash = '0;
    logic          in_inc = 1'b0;
    logic          clear_req = 1'b0;
    logic          clear_busy;
    logic          out_valid;
    logic [CW-1:0] out_count;
    logic          out_sat;
    logic          drop;

    cm_sketch_row_counter #(.W(W), .HASH_SIZE(HS), .CNT_SIZE(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_hash    (in_hash),
        .in_inc     (in_inc),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .out_valid  (out_valid),
        .out_count  (out_count),
        .out_sat    (out_sat),
        .drop       (drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [CW-1:0] cnt;
        logic          sat;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;
    int   drop_cnt = 0;

    // Monitor: every result must match the oldest outstanding expectation
    // and arrive exactly two cycles after its input was presented.
    always @(negedge clk) begin
        if (rst_n) begin
            if (drop) drop_cnt++;
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_result got count=%0d sat=%0d at cycle %0d, required no result",
                             out_count, out_sat, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (out_count == mon_e.cnt && out_sat == mon_e.sat && cyc == mon_e.cyc + 2) begin
                        passes++;
                        $display("result count=%0d sat=%0d cycle=%0d", out_count, out_sat, cyc);
                    end else begin
                        $display("FAIL result got count=%0d sat=%0d cycle=%0d, required count=%0d sat=%0d cycle=%0d",
                                 out_count, out_sat, cyc, mon_e.cnt, mon_e.sat, mon_e.cyc + 2);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int need);
        checks++;
        if (got == need) begin
            passes++;
            $display("check %s = %0d", name, got);
        end else begin
            $display("FAIL %s got %0d, required %0d", name, got, need);
        end
    endtask

    task automatic op(input logic [HS-1:0] h, input logic inc, input logic [CW-1:0] exp_cnt);
        exp_t e;
        in_valid  = 1'b1;
        in_hash   = h;
        in_inc    = inc;
        clear_req = 1'b0;
        e.cnt = exp_cnt;
        e.sat = (exp_cnt == 4'd15);
        e.cyc = cyc;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        in_inc    = 1'b0;
        clear_req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (clear_busy && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        int quiet_bad;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_clear_busy", int'(clear_busy), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_count", int'(out_count), 0);
        check("rst_drop", int'(drop), 0);

        // Startup sweep: busy for W cycles, outputs quiet throughout
        rst_n = 1'b1;
        n = 0;
        quiet_bad = 0;
        while (clear_busy && n < 40) begin
            if (out_valid || out_count != 0 || drop) quiet_bad++;
            n++;
            @(negedge clk);
        end
        check("startup_busy_cycles", n, 16);
        check("startup_quiet", quiet_bad, 0);

        // First input in the cycle clear_busy falls
        op(4'd5, 1'b0, 4'd0);

        // Back-to-back same-index increments
        op(4'd3, 1'b1, 4'd1);
        op(4'd3, 1'b1, 4'd2);
        op(4'd3, 1'b1, 4'd3);
        op(4'd3, 1'b1, 4'd4);
        op(4'd3, 1'b0, 4'd4);

        // Interleaved indices
        op(4'd7, 1'b1, 4'd1);
        op(4'd9, 1'b1, 4'd1);
        op(4'd7, 1'b1, 4'd2);
        op(4'd9, 1'b1, 4'd2);
        op(4'd7, 1'b1, 4'd3);

        // Saturation at 15
        for (int i = 1; i <= 17; i++) begin
            op(4'd0, 1'b1, (i <= 15) ? 4'(i) : 4'd15);
        end
        op(4'd0, 1'b0, 4'd15);
        idle(4);

        // Clear with traffic: input alongside clear_req is dropped
        op(4'd2, 1'b1, 4'd1);
        op(4'd2, 1'b1, 4'd2);
        op(4'd2, 1'b1, 4'd3);
        in_valid  = 1'b1;
        in_hash   = 4'd2;
        in_inc    = 1'b1;
        clear_req = 1'b1;
        @(negedge clk);
        idle(0);
        count_busy(n);
        check("clear_busy_cycles", n, 16);
        check("clear_inflight_done", exp_q.size(), 0);
        check("clear_drop_count", drop_cnt, 1);
        op(4'd2, 1'b1, 4'd1);
        op(4'd3, 1'b0, 4'd0);
        op(4'd0, 1'b0, 4'd0);
        idle(4);

        // Reset mid-sweep
        op(4'd12, 1'b1, 4'd1);
        op(4'd14, 1'b1, 4'd1);
        op(4'd14, 1'b1, 4'd2);
        op(4'd5, 1'b1, 4'd1);
        idle(3);
        clear_req = 1'b1;
        @(negedge clk);
        idle(2);
        in_valid = 1'b1;
        in_hash  = 4'd7;
        in_inc   = 1'b1;
        @(negedge clk);
        idle(5);
        check("sweep_drop_count", drop_cnt, 2);
        check("sweep_busy_before_reset", int'(clear_busy), 1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_reset_out_valid", int'(out_valid), 0);
        rst_n = 1'b1;
        count_busy(n);
        check("restart_busy_cycles", n, 16);
        op(4'd12, 1'b0, 4'd0);
        op(4'd14, 1'b0, 4'd0);
        op(4'd5, 1'b0, 4'd0);
        op(4'd7, 1'b0, 4'd0);
        op(4'd3, 1'b1, 4'd1);
        idle(1);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("final_queue_empty", exp_q.size(), 0);
        idle(2);
        check("final_drop_count", drop_cnt, 2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
